// File: rtl/grant_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | grant_scheduler: round-robin owner arbiter with valid/ready offer and   |
// | hold-until-release ownership of a single shared resource.               |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module grant_scheduler #(
  parameter int OUT_WIDTH = 2,
  parameter int LINES     = 1 << OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [LINES-1:0]     req,
  output logic                 grant_valid,
  input  logic                 grant_ready,
  output logic [OUT_WIDTH-1:0] grant_index,
  output logic [LINES-1:0]     grant_onehot,
  output logic                 busy,
  // owner-finished strobe ("release" itself is a reserved word)
  input  logic                 grant_release
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] last_q, last_d;
  logic [OUT_WIDTH-1:0] grant_index_q, grant_index_d;
  logic [OUT_WIDTH-1:0] win;
  logic [OUT_WIDTH:0]   pos;

  // Rotated view: slot k maps to requester (last + k) mod LINES, highest slot
  // wins, so the search runs last-1, last-2, ... wrapping below 0.
  always_comb begin
    win = '0;
    pos = '0;
    for (int k = 0; k < LINES; k++) begin
      pos = {1'b0, last_q} + (OUT_WIDTH+1)'(k);
      if (pos >= (OUT_WIDTH+1)'(LINES)) begin
        pos = pos - (OUT_WIDTH+1)'(LINES);
      end
      if (req[pos[OUT_WIDTH-1:0]]) begin
        win = pos[OUT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_index_d = grant_index_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d       = ST_OFFER;
          grant_index_d = win;
        end
      end
      ST_OFFER: begin
        if (grant_ready) begin
          state_d = ST_BUSY;
          last_d  = grant_index_q;
        end
      end
      ST_BUSY: begin
        if (grant_release) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      last_q        <= '0;
      grant_index_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_index_q <= grant_index_d;
    end
  end

  assign grant_valid = (state_q == ST_OFFER);
  assign busy        = (state_q == ST_BUSY);
  assign grant_index = grant_index_q;

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < LINES; i++) begin
      grant_onehot[i] = (state_q != ST_IDLE) && (grant_index_q == OUT_WIDTH'(i));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grant_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_grant_scheduler: randomized + directed bench for grant_scheduler,    |
// | LINES=4 and LINES=3 instances against a behavioural model.              |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_grant_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req4 = '0;
  logic [2:0] req3 = '0;
  logic       gr = 1'b0;
  logic       rl = 1'b0;

  logic       v4, b4;
  logic [1:0] idx4;
  logic [3:0] oh4;
  logic       v3, b3;
  logic [1:0] idx3;
  logic [2:0] oh3;

  grant_scheduler #(.OUT_WIDTH(2), .LINES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .grant_valid(v4),
    .grant_ready(gr), .grant_index(idx4), .grant_onehot(oh4),
    .busy(b4), .grant_release(rl)
  );

  grant_scheduler #(.OUT_WIDTH(2), .LINES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .grant_valid(v3),
    .grant_ready(gr), .grant_index(idx3), .grant_onehot(oh3),
    .busy(b3), .grant_release(rl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: phase 0 idle, 1 offered, 2 owned
  int m_state[2];
  int m_last[2];
  int m_idx[2];
  int acc4[$];
  int acc3[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First requester met walking down from last-1, wrapping at 0.
  function automatic int pick(input logic [3:0] r, input int last, input int lines);
    for (int s = 1; s <= lines; s++) begin
      int i;
      i = (((last - s) % lines) + lines) % lines;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0;
      m_last[d]  = 0;
      m_idx[d]   = 0;
    end
  endtask

  task automatic model_clock(input logic [3:0] r, input logic g, input logic l);
    for (int d = 0; d < 2; d++) begin
      int lines;
      logic [3:0] rr;
      lines = (d == 0) ? 4 : 3;
      rr    = (d == 0) ? r : {1'b0, r[2:0]};
      if (m_state[d] == 0) begin
        if (rr != 4'd0) begin
          m_state[d] = 1;
          m_idx[d]   = pick(rr, m_last[d], lines);
        end
      end else if (m_state[d] == 1) begin
        if (g) begin
          m_state[d] = 2;
          m_last[d]  = m_idx[d];
        end
      end else begin
        if (l) m_state[d] = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/valid4"}, int'(v4), (m_state[0] == 1) ? 1 : 0);
    chk({tag, "/busy4"},  int'(b4), (m_state[0] == 2) ? 1 : 0);
    chk({tag, "/index4"}, int'(idx4), m_idx[0]);
    chk({tag, "/onehot4"}, int'(oh4), (m_state[0] != 0) ? (1 << m_idx[0]) : 0);
    chk({tag, "/valid3"}, int'(v3), (m_state[1] == 1) ? 1 : 0);
    chk({tag, "/busy3"},  int'(b3), (m_state[1] == 2) ? 1 : 0);
    chk({tag, "/index3"}, int'(idx3), m_idx[1]);
    chk({tag, "/onehot3"}, int'(oh3), (m_state[1] != 0) ? (1 << m_idx[1]) : 0);
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic step(input string tag, input logic [3:0] r, input logic g, input logic l);
    req4 = r;
    req3 = r[2:0];
    gr   = g;
    rl   = l;
    #1;
    if (v4 && g) acc4.push_back(int'(idx4));
    if (v3 && g) acc3.push_back(int'(idx3));
    @(posedge clk);
    model_clock(r, g, l);
    #1;
    check_outputs(tag);
  endtask

  task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
    chk({tag, "/count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s/acc%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;

    // all requesting, accept and release immediately
    acc4.delete();
    acc3.delete();
    repeat (15) step("rr_all", 4'b1111, 1'b1, 1'b1);
    chk_seq("seq4", acc4, '{3, 2, 1, 0, 3});
    chk_seq("seq3", acc3, '{2, 1, 0, 2, 1});

    // offer frozen while not accepted, even after req changes
    acc4.delete();
    acc3.delete();
    step("hold", 4'b0010, 1'b0, 1'b0);
    chk("hold_onehot", int'(oh4), 2);
    for (int i = 0; i < 5; i++) begin
      step("hold", (i < 2) ? 4'b0010 : 4'b1000, 1'b0, 1'b0);
      chk("hold_idx", int'(idx4), 1);
    end
    step("hold_acc", 4'b1000, 1'b1, 1'b0);
    step("hold_rel", 4'b0000, 1'b0, 1'b1);

    step("acc2", 4'b0100, 1'b0, 1'b0);
    step("acc2", 4'b0100, 1'b1, 1'b0);
    step("acc2", 4'b0000, 1'b0, 1'b1);
    repeat (6) step("pair", 4'b0101, 1'b1, 1'b1);
    chk_seq("pair4", acc4, '{1, 2, 0, 2});
    chk_seq("pair3", acc3, '{1, 2, 0, 2});

    // ownership survives stray ready and req churn
    step("own", 4'b1111, 1'b0, 1'b0);
    step("own", 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      step("own", r, 1'(i % 2), 1'b0);
      chk("own_busy", int'(b4), 1);
    end
    step("own_rel", 4'b0000, 1'b0, 1'b1);
    chk("own_idle", int'(b4 | v4), 0);

    // async reset while owned
    step("pre_rst", 4'b0110, 1'b0, 1'b0);
    step("pre_rst", 4'b0110, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", int'(b4), 0);
    chk("rst_onehot", int'(oh4), 0);
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post_rst", 4'b1111, 1'b0, 1'b0);
    chk("post_rst_idx", int'(idx4), 3);
    step("post_rst", 4'b0001, 1'b0, 1'b0);
    step("post_rst", 4'b0001, 1'b1, 1'b0);
    step("post_rst", 4'b0000, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("one", 4'b0001, 1'b0, 1'b0);
    chk("one_idx", int'(idx4), 0);
    step("one", 4'b0001, 1'b1, 1'b0);
    step("one", 4'b0000, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic g, l;
      r = 4'($urandom);
      g = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 2) == 0);
      step("rand", r, g, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
